// File: rtl/mips_defs.sv
// Shared MIPS decode constants: opcodes/functs, instruction classes, Tuse/Tnew, forward selects.
// Holds the helpers used by the hazard controller to resolve stalls and forwarding.
package mips_defs;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_ORI     = 6'h0d;
  localparam logic [5:0] OP_LUI     = 6'h0f;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2b;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1a;
  localparam logic [5:0] FN_DIVU  = 6'h1b;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2a;

  typedef enum logic [3:0] {
    CL_NOP, CL_ALU_R, CL_ALU_I, CL_LOAD, CL_STORE, CL_BEQ,
    CL_JR, CL_JAL, CL_J, CL_MD, CL_MF, CL_MT
  } instr_class_t;

  // TUSE_NA marks an operand that is not read; its register is reported as 0.
  localparam logic [1:0] TUSE_0  = 2'd0;
  localparam logic [1:0] TUSE_1  = 2'd1;
  localparam logic [1:0] TUSE_2  = 2'd2;
  localparam logic [1:0] TUSE_NA = 2'd3;

  localparam logic [1:0] TNEW_0    = 2'd0;
  localparam logic [1:0] TNEW_ALU  = 2'd1;
  localparam logic [1:0] TNEW_LOAD = 2'd2;

  localparam logic [1:0] FWD_RF = 2'd0;
  localparam logic [1:0] FWD_E  = 2'd1;
  localparam logic [1:0] FWD_M  = 2'd2;
  localparam logic [1:0] FWD_W  = 2'd3;

  function automatic logic [1:0] tnew_next(input logic [1:0] t);
    return (t == TNEW_0) ? TNEW_0 : t - 2'd1;
  endfunction

  function automatic logic [1:0] fwd_pick(
    input logic [4:0] r,
    input logic [4:0] a3_e, input logic [1:0] tn_e,
    input logic [4:0] a3_m, input logic [1:0] tn_m,
    input logic [4:0] a3_w, input logic [1:0] tn_w
  );
    if (r == 5'd0)                        return FWD_RF;
    if (a3_e == r && tn_e == TNEW_0)      return FWD_E;
    if (a3_m == r && tn_m == TNEW_0)      return FWD_M;
    if (a3_w == r && tn_w == TNEW_0)      return FWD_W;
    return FWD_RF;
  endfunction

  // Nearest producer decides: an EX match hides any MEM match for the same register.
  function automatic logic data_hazard(
    input logic [4:0] r, input logic [1:0] tuse,
    input logic [4:0] a3_e, input logic [1:0] tn_e,
    input logic [4:0] a3_m, input logic [1:0] tn_m
  );
    if (r == 5'd0)  return 1'b0;
    if (a3_e == r)  return tn_e > tuse;
    if (a3_m == r)  return tn_m > tuse;
    return 1'b0;
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard controller bundle: stage instruction words in, stall/forward/MDU controls out.
interface hazard_ctrl_if;
  logic [31:0] IR_D;
  logic [31:0] IR_E;
  logic [31:0] IR_M;
  logic [31:0] IR_W;
  logic        stall;
  logic        md_start;
  logic        md_busy;
  logic [1:0]  fwd_rs_D;
  logic [1:0]  fwd_rt_D;
  logic [1:0]  fwd_rs_E;
  logic [1:0]  fwd_rt_E;
  logic        fwd_rt_M;

  modport master (
    output IR_D, IR_E, IR_M, IR_W,
    input  stall, md_start, md_busy, fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E, fwd_rt_M
  );

  modport slave (
    input  IR_D, IR_E, IR_M, IR_W,
    output stall, md_start, md_busy, fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E, fwd_rt_M
  );
endinterface

// File: rtl/instr_class_dec.sv
// Combinational decode of one instruction word into class, operand regs, A3, Tuse and Tnew (as in EX).
// Zero latency; unused operands are reported as register 0 so they can never match a producer.
module instr_class_dec
  import mips_defs::*;
(
  input  logic [31:0]  ir,
  output instr_class_t cls,
  output logic [4:0]   rs,
  output logic [4:0]   rt,
  output logic [4:0]   a3,
  output logic [1:0]   tuse_rs,
  output logic [1:0]   tuse_rt,
  output logic [1:0]   tnew_e
);

  logic [5:0] op;
  logic [5:0] fn;
  logic [4:0] f_rs;
  logic [4:0] f_rt;
  logic [4:0] f_rd;
  logic       unused_shamt;

  assign op           = ir[31:26];
  assign f_rs         = ir[25:21];
  assign f_rt         = ir[20:16];
  assign f_rd         = ir[15:11];
  assign fn           = ir[5:0];
  assign unused_shamt = ^ir[10:6];

  always_comb begin
    cls = CL_NOP;
    case (op)
      OP_SPECIAL: begin
        case (fn)
          FN_ADDU, FN_SUBU, FN_AND, FN_OR, FN_SLT: cls = CL_ALU_R;
          FN_JR:                                   cls = CL_JR;
          FN_MULT, FN_MULTU, FN_DIV, FN_DIVU:      cls = CL_MD;
          FN_MFHI, FN_MFLO:                        cls = CL_MF;
          FN_MTHI, FN_MTLO:                        cls = CL_MT;
          default:                                 cls = CL_NOP;
        endcase
      end
      OP_ORI, OP_LUI, OP_ADDIU: cls = CL_ALU_I;
      OP_LW:                    cls = CL_LOAD;
      OP_SW:                    cls = CL_STORE;
      OP_BEQ:                   cls = CL_BEQ;
      OP_JAL:                   cls = CL_JAL;
      OP_J:                     cls = CL_J;
      default:                  cls = CL_NOP;
    endcase
  end

  always_comb begin
    rs      = 5'd0;
    rt      = 5'd0;
    a3      = 5'd0;
    tuse_rs = TUSE_NA;
    tuse_rt = TUSE_NA;
    tnew_e  = TNEW_0;
    case (cls)
      CL_ALU_R: begin
        rs = f_rs; tuse_rs = TUSE_1;
        rt = f_rt; tuse_rt = TUSE_1;
        a3 = f_rd; tnew_e  = TNEW_ALU;
      end
      CL_ALU_I: begin
        rs = f_rs; tuse_rs = TUSE_1;
        a3 = f_rt; tnew_e  = TNEW_ALU;
      end
      CL_LOAD: begin
        rs = f_rs; tuse_rs = TUSE_1;
        a3 = f_rt; tnew_e  = TNEW_LOAD;
      end
      CL_STORE: begin
        rs = f_rs; tuse_rs = TUSE_1;
        rt = f_rt; tuse_rt = TUSE_2;
      end
      CL_BEQ: begin
        rs = f_rs; tuse_rs = TUSE_0;
        rt = f_rt; tuse_rt = TUSE_0;
      end
      CL_JR: begin
        rs = f_rs; tuse_rs = TUSE_0;
      end
      CL_JAL: begin
        a3 = 5'd31; tnew_e = TNEW_0;
      end
      CL_MD: begin
        rs = f_rs; tuse_rs = TUSE_1;
        rt = f_rt; tuse_rt = TUSE_1;
      end
      CL_MF: begin
        a3 = f_rd; tnew_e = TNEW_ALU;
      end
      CL_MT: begin
        rs = f_rs; tuse_rs = TUSE_1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Stall, forward-select and MDU sequencing for the 5-stage pipeline; all outputs combinational
// from the stage IRs plus a 4-bit MDU busy counter (the only state, cleared asynchronously).
module hazard_ctrl
  import mips_defs::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
)
(
  input  logic         CLK,
  input  logic         reset,
  hazard_ctrl_if.slave bus
);

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

  instr_class_t cls_d, cls_e, cls_m, cls_w;
  logic [4:0]   rs_d, rt_d, a3_d;
  logic [4:0]   rs_e, rt_e, a3_e;
  logic [4:0]   rs_m, rt_m, a3_m;
  logic [4:0]   rs_w, rt_w, a3_w;
  logic [1:0]   tuse_rs_d, tuse_rt_d;
  logic [1:0]   tuse_rs_e, tuse_rt_e, tuse_rs_m, tuse_rt_m, tuse_rs_w, tuse_rt_w;
  logic [1:0]   tnew_d_raw, tnew_e, tnew_m_raw, tnew_w_raw;
  logic [1:0]   tnew_m, tnew_w;
  logic [3:0]   md_cnt;
  logic         md_start_c, md_busy_c;
  logic         data_stall, md_stall;
  logic         unused_dec;

  instr_class_dec u_dec_d (
    .ir(bus.IR_D), .cls(cls_d), .rs(rs_d), .rt(rt_d), .a3(a3_d),
    .tuse_rs(tuse_rs_d), .tuse_rt(tuse_rt_d), .tnew_e(tnew_d_raw)
  );
  instr_class_dec u_dec_e (
    .ir(bus.IR_E), .cls(cls_e), .rs(rs_e), .rt(rt_e), .a3(a3_e),
    .tuse_rs(tuse_rs_e), .tuse_rt(tuse_rt_e), .tnew_e(tnew_e)
  );
  instr_class_dec u_dec_m (
    .ir(bus.IR_M), .cls(cls_m), .rs(rs_m), .rt(rt_m), .a3(a3_m),
    .tuse_rs(tuse_rs_m), .tuse_rt(tuse_rt_m), .tnew_e(tnew_m_raw)
  );
  instr_class_dec u_dec_w (
    .ir(bus.IR_W), .cls(cls_w), .rs(rs_w), .rt(rt_w), .a3(a3_w),
    .tuse_rs(tuse_rs_w), .tuse_rt(tuse_rt_w), .tnew_e(tnew_w_raw)
  );

  assign unused_dec = ^{cls_m, cls_w, a3_d, tnew_d_raw, rs_m, rs_w, rt_w,
                        tuse_rs_e, tuse_rt_e, tuse_rs_m, tuse_rt_m, tuse_rs_w, tuse_rt_w};

  assign tnew_m = tnew_next(tnew_m_raw);
  assign tnew_w = tnew_next(tnew_next(tnew_w_raw));

  assign data_stall = data_hazard(rs_d, tuse_rs_d, a3_e, tnew_e, a3_m, tnew_m)
                    | data_hazard(rt_d, tuse_rt_d, a3_e, tnew_e, a3_m, tnew_m);

  assign md_start_c = (cls_e == CL_MD);
  assign md_busy_c  = (md_cnt != 4'd0);
  assign md_stall   = (cls_d inside {CL_MD, CL_MF, CL_MT}) && (md_busy_c || md_start_c);

  // Funct bit 1 separates div/divu from mult/multu.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      md_cnt <= 4'd0;
    end else if (md_start_c) begin
      md_cnt <= bus.IR_E[1] ? DIV_LOAD : MULT_LOAD;
    end else if (md_busy_c) begin
      md_cnt <= md_cnt - 4'd1;
    end
  end

  assign bus.stall    = data_stall | md_stall;
  assign bus.md_start = md_start_c;
  assign bus.md_busy  = md_busy_c;
  assign bus.fwd_rs_D = fwd_pick(rs_d, a3_e, tnew_e, a3_m, tnew_m, a3_w, tnew_w);
  assign bus.fwd_rt_D = fwd_pick(rt_d, a3_e, tnew_e, a3_m, tnew_m, a3_w, tnew_w);
  assign bus.fwd_rs_E = fwd_pick(rs_e, 5'd0, TNEW_0, a3_m, tnew_m, a3_w, tnew_w);
  assign bus.fwd_rt_E = fwd_pick(rt_e, 5'd0, TNEW_0, a3_m, tnew_m, a3_w, tnew_w);
  assign bus.fwd_rt_M = (fwd_pick(rt_m, 5'd0, TNEW_0, 5'd0, TNEW_0, a3_w, tnew_w) == FWD_W);

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl: hand-placed IR_D/E/M/W per cycle, hand-computed expectations.
module tb_hazard_ctrl;

  logic CLK = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;
  int   stall_cycles;

  hazard_ctrl_if bus ();

  hazard_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .CLK  (CLK),
    .reset(reset),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] rtype(input logic [5:0] fn, input logic [4:0] rs, rt, rd);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, rt,
                                        input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  localparam logic [31:0] NOP = 32'h0;
  localparam logic [31:0] JAL = {6'h03, 26'h0000040};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock, then present the four stage IRs; outputs settle before the check point.
  task automatic cyc(input logic [31:0] d, e, m, w);
    @(posedge CLK);
    #1;
    bus.IR_D = d;
    bus.IR_E = e;
    bus.IR_M = m;
    bus.IR_W = w;
    #1;
  endtask

  task automatic chk_fwd(input string tag, input logic [1:0] rs_d, rt_d, rs_e, rt_e,
                         input logic rt_m);
    chk({tag, ".fwd_rs_D"}, 32'(bus.fwd_rs_D), 32'(rs_d));
    chk({tag, ".fwd_rt_D"}, 32'(bus.fwd_rt_D), 32'(rt_d));
    chk({tag, ".fwd_rs_E"}, 32'(bus.fwd_rs_E), 32'(rs_e));
    chk({tag, ".fwd_rt_E"}, 32'(bus.fwd_rt_E), 32'(rt_e));
    chk({tag, ".fwd_rt_M"}, 32'(bus.fwd_rt_M), 32'(rt_m));
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] addu1, beq1, lw4, addu5, jr31, divi, mfhi4, multi, mflo4;
    addu1 = rtype(6'h21, 5'd2, 5'd3, 5'd1);
    beq1  = itype(6'h04, 5'd1, 5'd0, 16'h0004);
    lw4   = itype(6'h23, 5'd0, 5'd4, 16'h0000);
    addu5 = rtype(6'h21, 5'd4, 5'd4, 5'd5);
    jr31  = rtype(6'h08, 5'd31, 5'd0, 5'd0);
    divi  = rtype(6'h1a, 5'd2, 5'd3, 5'd0);
    mfhi4 = rtype(6'h10, 5'd0, 5'd0, 5'd4);
    multi = rtype(6'h18, 5'd2, 5'd3, 5'd0);
    mflo4 = rtype(6'h12, 5'd0, 5'd0, 5'd4);

    reset    = 1'b1;
    bus.IR_D = NOP;
    bus.IR_E = NOP;
    bus.IR_M = NOP;
    bus.IR_W = NOP;
    #2;
    chk("rst.stall",    32'(bus.stall),    32'd0);
    chk("rst.md_start", 32'(bus.md_start), 32'd0);
    chk("rst.md_busy",  32'(bus.md_busy),  32'd0);
    chk_fwd("rst", 2'd0, 2'd0, 2'd0, 2'd0, 1'b0);
    @(negedge CLK);
    reset = 1'b0;

    // addu $1 in EX feeding beq in ID: one bubble, then MEM forward.
    cyc(beq1, addu1, NOP, NOP);
    chk("alu_beq.stall", 32'(bus.stall), 32'd1);
    cyc(beq1, NOP, addu1, NOP);
    chk("alu_beq2.stall", 32'(bus.stall), 32'd0);
    chk_fwd("alu_beq2", 2'd2, 2'd0, 2'd0, 2'd0, 1'b0);

    // load-use: one bubble, then both ALU operands from WB.
    cyc(addu5, lw4, NOP, NOP);
    chk("lw_use.stall", 32'(bus.stall), 32'd1);
    cyc(addu5, NOP, lw4, NOP);
    chk("lw_use2.stall", 32'(bus.stall), 32'd0);
    chk("lw_use2.fwd_rs_D", 32'(bus.fwd_rs_D), 32'd0);
    cyc(NOP, addu5, NOP, lw4);
    chk("lw_use3.stall", 32'(bus.stall), 32'd0);
    chk_fwd("lw_use3", 2'd0, 2'd0, 2'd3, 2'd3, 1'b0);

    // jal in EX, jr $31 in ID: forward PC8_E.
    cyc(jr31, JAL, NOP, NOP);
    chk("jal_jr.stall", 32'(bus.stall), 32'd0);
    chk("jal_jr.fwd_rs_D", 32'(bus.fwd_rs_D), 32'd1);

    // EX match masks a stalling MEM lw $31, and EX beats MEM.
    cyc(jr31, JAL, itype(6'h23, 5'd0, 5'd31, 16'h0), NOP);
    chk("mask.stall", 32'(bus.stall), 32'd0);
    chk("mask.fwd_rs_D", 32'(bus.fwd_rs_D), 32'd1);

    // MEM beats WB for EX consumer; store data from WB.
    cyc(NOP, rtype(6'h21, 5'd6, 5'd6, 5'd7), itype(6'h0d, 5'd0, 5'd6, 16'h1),
        itype(6'h23, 5'd0, 5'd6, 16'h0));
    chk_fwd("m_over_w", 2'd0, 2'd0, 2'd2, 2'd2, 1'b0);
    cyc(NOP, NOP, itype(6'h2b, 5'd0, 5'd6, 16'h0), rtype(6'h21, 5'd1, 5'd2, 5'd6));
    chk("sw_fwd.fwd_rt_M", 32'(bus.fwd_rt_M), 32'd1);

    // Store data has Tuse 2: lw in EX does not stall sw rt.
    cyc(itype(6'h2b, 5'd9, 5'd8, 16'h0), itype(6'h23, 5'd0, 5'd8, 16'h0), NOP, NOP);
    chk("lw_sw.stall", 32'(bus.stall), 32'd0);

    // Register $0 never forms a dependence.
    cyc(rtype(6'h21, 5'd0, 5'd0, 5'd5), itype(6'h23, 5'd1, 5'd0, 16'h0),
        rtype(6'h21, 5'd1, 5'd2, 5'd0), itype(6'h0d, 5'd0, 5'd0, 16'h3));
    chk("zero.stall", 32'(bus.stall), 32'd0);
    chk_fwd("zero", 2'd0, 2'd0, 2'd0, 2'd0, 1'b0);

    // div in EX with mfhi waiting: 11 stall cycles, busy 10.
    cyc(mfhi4, divi, NOP, NOP);
    chk("div.md_start", 32'(bus.md_start), 32'd1);
    chk("div.stall",    32'(bus.stall),    32'd1);
    chk("div.md_busy",  32'(bus.md_busy),  32'd0);
    stall_cycles = 1;
    for (int k = 1; k <= 11; k++) begin
      cyc(mfhi4, NOP, NOP, NOP);
      chk($sformatf("div.t%0d.md_busy", k), 32'(bus.md_busy), (k <= 10) ? 32'd1 : 32'd0);
      chk($sformatf("div.t%0d.md_start", k), 32'(bus.md_start), 32'd0);
      if (bus.stall) stall_cycles++;
    end
    chk("div.stall_total", 32'(stall_cycles), 32'd11);

    // mult start, then reset mid-count clears busy at once.
    cyc(NOP, multi, NOP, NOP);
    chk("mult.md_start", 32'(bus.md_start), 32'd1);
    cyc(NOP, NOP, NOP, NOP);
    cyc(NOP, NOP, NOP, NOP);
    cyc(NOP, NOP, NOP, NOP);
    chk("mult.t3.md_busy", 32'(bus.md_busy), 32'd1);
    reset = 1'b1;
    #1;
    chk("rst_mid.md_busy", 32'(bus.md_busy), 32'd0);
    bus.IR_D = mflo4;
    #1;
    chk("rst_mid.stall", 32'(bus.stall), 32'd0);
    @(negedge CLK);
    reset = 1'b0;
    cyc(mflo4, NOP, NOP, NOP);
    chk("post_rst.stall",   32'(bus.stall),   32'd0);
    chk("post_rst.md_busy", 32'(bus.md_busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
